// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, issues one icache lookup at a time, falls back to the
// memory bus on a miss and queues {pc, word} for decode. Define IFETCH_PERF_EN for hit/miss counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ic_addr,
  output logic        ic_valid,
  input  logic        ic_hit,
  input  logic [31:0] ic_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);
  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(IQ_DEPTH);

  typedef enum logic [1:0] {FETCH, CHECK, MISS} state_t;

  state_t           state_q;
  logic [31:0]      pc_q;
  logic             squash_q;
  logic [31:0]      iq_pc_q   [IQ_DEPTH];
  logic [31:0]      iq_data_q [IQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic        push;
  logic        pop;
  logic [31:0] push_data;
  logic [31:0] redirect_target;
  logic        iq_has_room;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign iq_has_room     = count_q < DEPTH;

  assign ic_valid   = (state_q == FETCH) && iq_has_room && !reset;
  assign ic_addr    = pc_q;
  assign mem_req    = (state_q == MISS);
  assign mem_addr   = pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_pc    = iq_pc_q[rd_ptr_q];
  assign inst_data  = iq_data_q[rd_ptr_q];

  // A redirect swallows both the pop and any word arriving in the same cycle.
  assign pop = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    push      = 1'b0;
    push_data = ic_data;
    if (!redirect_valid) begin
      if (state_q == CHECK) begin
        push = ic_hit;
      end else if ((state_q == MISS) && mem_ack && !squash_q) begin
        push      = 1'b1;
        push_data = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        iq_pc_q[i]   <= '0;
        iq_data_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        iq_pc_q[wr_ptr_q]   <= pc_q;
        iq_data_q[wr_ptr_q] <= push_data;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // A redirect during MISS must still wait out the bus beat; squash_q marks it as dead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            pc_q <= redirect_target;
          end else if (iq_has_room) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (redirect_valid) begin
            pc_q    <= redirect_target;
            state_q <= FETCH;
          end else if (ic_hit) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= FETCH;
          end else begin
            state_q <= MISS;
          end
        end
        MISS: begin
          if (redirect_valid) begin
            pc_q     <= redirect_target;
            squash_q <= !mem_ack;
            if (mem_ack) begin
              state_q <= FETCH;
            end
          end else if (mem_ack) begin
            if (!squash_q) begin
              pc_q <= pc_q + 32'd4;
            end
            squash_q <= 1'b0;
            state_q  <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_hits_q;
  logic [31:0] perf_misses_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else if (state_q == CHECK) begin
      if (ic_hit) begin
        if (perf_hits_q != '1) perf_hits_q <= perf_hits_q + 32'd1;
      end else begin
        if (perf_misses_q != '1) perf_misses_q <= perf_misses_q + 32'd1;
      end
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios, then randomized cache/memory/decode/redirect
// traffic checked against an in-order instruction-stream model.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic        ic_hit = 1'b0;
  logic [31:0] ic_data = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
`endif

  ifetch_unit #(.RESET_PC(32'h0), .IQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_hit(ic_hit), .ic_data(ic_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef IFETCH_PERF_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Environment knobs
  int          hit_mode = 0;        // 0 all hit, 1 miss only at miss_addr, 2 hashed
  logic [31:0] miss_addr = '0;
  logic [31:0] hash_seed = '0;
  int unsigned ready_prob = 100;
  int unsigned redirect_prob = 0;
  int          ack_delay = 3;       // negative: random 0..4
  bit          junk_en = 1'b0;
  bit          force_redirect = 1'b0;
  logic [31:0] force_target = '0;
  bit          force_ack = 1'b0;

  // Reference model and environment state
  logic [31:0] exp_pc;
  int          delivered = 0;
  bit          prev_ic_valid, prev_redirect, prev_mem_busy, prev_mem_req;
  logic [31:0] prev_ic_addr, prev_target, last_lookup_addr, req_addr;
  int          req_age, cur_delay;
  bit          s_ic_valid, s_mem_req, s_inst_valid;
  logic [31:0] s_ic_addr, s_mem_addr, s_inst_pc, s_inst_data;

  function automatic logic [31:0] cache_word(input logic [31:0] p);
    return p ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] p);
    return (p == 32'h10) ? 32'hDEAD_BEEF : ~p;
  endfunction

  function automatic bit hit_of(input logic [31:0] p);
    logic [31:0] h;
    h = (p ^ hash_seed) * 32'h9E37_79B1;
    case (hit_mode)
      0:       return 1'b1;
      1:       return p != miss_addr;
      default: return h[31:29] < 3'd5;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] p);
    return hit_of(p) ? cache_word(p) : mem_word(p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of environment: sample DUT, check redirect effects, play cache/memory/decode.
  task automatic cycle_body();
    logic [31:0] tgt;
    s_ic_valid = ic_valid;     s_ic_addr = ic_addr;
    s_mem_req = mem_req;       s_mem_addr = mem_addr;
    s_inst_valid = inst_valid; s_inst_pc = inst_pc; s_inst_data = inst_data;

    if (prev_redirect) begin
      chk("redir_flush", 32'(s_inst_valid), 32'd0);
      if (prev_mem_busy) begin
        chk("redir_hold_req", 32'(s_mem_req), 32'd1);
        chk("redir_no_lookup", 32'(s_ic_valid), 32'd0);
      end else begin
        chk("redir_lookup", 32'(s_ic_valid), 32'd1);
        chk("redir_addr", s_ic_addr, prev_target);
      end
    end
    if (s_mem_req && !prev_mem_req) begin
      chk("miss_addr", s_mem_addr, last_lookup_addr);
      req_addr  = s_mem_addr;
      req_age   = 0;
      cur_delay = (ack_delay < 0) ? int'($urandom_range(4)) : ack_delay;
    end

    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (force_redirect) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_target;
    end else if (redirect_prob > 0 && $urandom_range(99) < redirect_prob) begin
      tgt = $urandom;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
    end
    inst_ready = ($urandom_range(99) < ready_prob);

    if (prev_ic_valid) begin
      ic_hit  = hit_of(prev_ic_addr);
      ic_data = ic_hit ? cache_word(prev_ic_addr) : $urandom;
    end else begin
      ic_hit  = junk_en ? 1'($urandom_range(1)) : 1'b0;
      ic_data = $urandom;
    end

    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (s_mem_req) begin
      if (force_ack || req_age == cur_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(req_addr);
        req_age   = 0;
      end else begin
        req_age++;
      end
    end else if (junk_en && $urandom_range(7) == 0) begin
      mem_ack = 1'b1;
    end

    if (s_inst_valid && inst_ready && !redirect_valid) begin
      chk("inst_pc", s_inst_pc, exp_pc);
      chk("inst_data", s_inst_data, exp_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};

    prev_ic_valid = s_ic_valid;
    prev_ic_addr  = s_ic_addr;
    if (s_ic_valid) last_lookup_addr = s_ic_addr;
    prev_redirect = redirect_valid;
    prev_target   = {redirect_pc[31:2], 2'b00};
    prev_mem_busy = s_mem_req && !mem_ack;
    prev_mem_req  = s_mem_req;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle_body();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_pc = 32'h0;
    prev_ic_valid = 0; prev_redirect = 0; prev_mem_busy = 0; prev_mem_req = 0;
    last_lookup_addr = 32'h0; req_age = 0; cur_delay = 0;
    #1;
    cycle_body();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    redirect_valid = 1'b0; mem_ack = 1'b0; ic_hit = 1'b0; inst_ready = 1'b0;
    force_redirect = 1'b0; force_ack = 1'b0;
    release_reset();
  endtask

  task automatic wait_mem_req(input int budget, input string tag);
    for (int k = 0; k < budget && !s_mem_req; k++) step();
    chk(tag, 32'(s_mem_req), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nval;
    // Values held during reset
    @(posedge clk);
    #1;
    chk("rst_ic_valid", 32'(ic_valid), 32'd0);
    chk("rst_ic_addr", ic_addr, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // All hits, decode always ready
    hit_mode = 0; ready_prob = 100;
    release_reset();
    chk("first_lookup", 32'(s_ic_valid), 32'd1);
    chk("first_lookup_addr", s_ic_addr, 32'h0);
    chk("c0_inst_valid", 32'(s_inst_valid), 32'd0);
    step();
    chk("c1_ic_valid", 32'(s_ic_valid), 32'd0);
    chk("c1_inst_valid", 32'(s_inst_valid), 32'd0);
    step();
    chk("hit_latency", 32'(s_inst_valid), 32'd1);
    for (int k = 3; k <= 12; k++) begin
      step();
      chk("hit_alternate", 32'(s_inst_valid), 32'((k % 2) == 0));
    end
    chk("hit_stream_pc", exp_pc, 32'h18);

    // Single miss at 0x10, ack three cycles after the request
    hit_mode = 1; miss_addr = 32'h10; ack_delay = 3;
    do_reset();
    wait_mem_req(40, "miss_req_seen");
    chk("miss_mem_addr", s_mem_addr, 32'h10);
    for (int k = 0; k < 10 && !mem_ack; k++) step();
    step();
    chk("miss_inst_valid", 32'(s_inst_valid), 32'd1);
    chk("miss_inst_pc", s_inst_pc, 32'h10);
    chk("miss_inst_data", s_inst_data, 32'hDEAD_BEEF);
    chk("miss_next_lookup", 32'(s_ic_valid), 32'd1);
    chk("miss_next_addr", s_ic_addr, 32'h14);

    // Decode stalled: queue fills then fetch stops
    hit_mode = 0; ready_prob = 0;
    do_reset();
    nval = int'(s_ic_valid);
    for (int k = 0; k < 15; k++) begin
      step();
      nval += int'(s_ic_valid);
    end
    chk("full_lookups", 32'(nval), 32'd4);
    chk("full_no_lookup", 32'(s_ic_valid), 32'd0);
    chk("full_inst_valid", 32'(s_inst_valid), 32'd1);
    chk("full_head_pc", s_inst_pc, 32'h0);
    ready_prob = 100;
    for (int k = 0; k < 20 && !s_ic_valid; k++) step();
    chk("resume_lookup", 32'(s_ic_valid), 32'd1);
    chk("resume_addr", s_ic_addr, 32'h10);
    for (int k = 0; k < 10; k++) step();

    // Redirect while a miss at 0x20 is outstanding
    hit_mode = 1; miss_addr = 32'h20; ack_delay = 1000;
    do_reset();
    wait_mem_req(60, "squash_req_seen");
    chk("squash_mem_addr", s_mem_addr, 32'h20);
    force_redirect = 1'b1; force_target = 32'h0000_1002;
    step();
    force_redirect = 1'b0;
    step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step();
    chk("squash_no_deliver", 32'(s_inst_valid), 32'd0);
    chk("squash_lookup", 32'(s_ic_valid), 32'd1);
    chk("squash_new_addr", s_ic_addr, 32'h1000);
    for (int k = 0; k < 4; k++) step();
    chk("squash_stream_pc", exp_pc, 32'h1008);

    // PC wraps at the top of the address space
    force_redirect = 1'b1; force_target = 32'hFFFF_FFFC;
    step();
    force_redirect = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("wrap_stream_pc", exp_pc, 32'h4);

    // Three hits then a miss; asynchronous reset in the middle of the miss
    hit_mode = 1; miss_addr = 32'hC; ack_delay = 1000;
    do_reset();
    wait_mem_req(40, "perf_req_seen");
`ifdef IFETCH_PERF_EN
    chk("perf_hits", perf_hits, 32'd3);
    chk("perf_misses", perf_misses, 32'd1);
`endif
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_ic_valid", 32'(ic_valid), 32'd0);
    chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
`ifdef IFETCH_PERF_EN
    chk("async_rst_hits", perf_hits, 32'd0);
    chk("async_rst_misses", perf_misses, 32'd0);
`endif

    // Randomized traffic
    hit_mode = 2; hash_seed = $urandom; junk_en = 1'b1;
    redirect_prob = 5; ack_delay = -1; ready_prob = 100;
    do_reset();
    delivered = 0;
    for (int blk = 0; blk < 20; blk++) begin
      ready_prob = $urandom_range(100);
      for (int k = 0; k < 200; k++) step();
    end
    chk("random_progress", 32'(delivered > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage sitting directly upstream of `icache`. It owns the program counter and presents one lookup at a time to the cache. On a miss it fetches the word from the memory bus. It buffers fetched instructions, with their PCs, in a small queue that drains to decode through a valid/ready handshake, and it supports a redirect (branch/exception) that flushes all in-flight work.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `IQ_DEPTH`, 4, instruction-queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `redirect_valid`  in  1  one-cycle pulse; load new PC, flush.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced 0).
- `ic_addr`  out  32  cache lookup address (= PC).
- `ic_valid`  out  1  cache lookup strobe.
- `ic_hit`  in  1  registered cache hit, valid the cycle after `ic_valid`.
- `ic_data`  in  32  registered cache data, paired with `ic_hit`.
- `mem_req`  out  1  memory read request, held until `mem_ack`.
- `mem_addr`  out  32  memory read address (= PC).
- `mem_ack`  in  1  one-cycle pulse; `mem_rdata` valid this cycle.
- `mem_rdata`  in  32  memory read data.
- `inst_valid`  out  1  queue head valid.
- `inst_data`  out  32  instruction at queue head.
- `inst_pc`  out  32  PC of the queue-head instruction.
- `inst_ready`  in  1  decode accepts the head this cycle.

## Operation
- State machine: FETCH, CHECK, MISS. Reset state is FETCH. At most one fetch is outstanding.
- FETCH:
  - If `count < IQ_DEPTH`: `ic_valid=1`, `ic_addr=pc`, next state CHECK.
  - Otherwise: stay in FETCH with `ic_valid=0`.
- CHECK:
  - `ic_hit=1`: push {pc, `ic_data`}, `pc<=pc+4`, next state FETCH.
  - `ic_hit=0`: next state MISS.
- MISS:
  - `mem_req=1`, `mem_addr=pc`.
  - On `mem_ack`: push {pc, `mem_rdata`}, `pc<=pc+4`, next state FETCH.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Queue:
  - Circular FIFO with a `$clog2(IQ_DEPTH)+1`-bit count.
  - Pop when `inst_valid && inst_ready`. Push and pop in the same cycle leave the count unchanged.
  - A push can never overflow: FETCH only issues when `count < IQ_DEPTH`, and the count cannot grow before the push.
- Redirect (highest priority, any state):
  - Queue emptied (count 0), and any pop in that cycle is ignored.
  - `pc<={redirect_pc[31:2],2'b00}`.
  - In FETCH or CHECK: next state FETCH; a pending `ic_hit`/`ic_data` is discarded.
  - In MISS: `mem_req` stays high until `mem_ack` and a squash flag is set. On `mem_ack` the word is discarded, the flag clears, and the next state is FETCH at the new PC.
  - A redirect and `mem_ack` in the same MISS cycle: the word is discarded; next state FETCH at `redirect_pc`.
- `mem_ack` outside MISS is ignored.

## Timing
- Reset values:
  - `ic_valid=0`, `ic_addr=RESET_PC`.
  - `mem_req=0`, `mem_addr=RESET_PC`.
  - `inst_valid=0`, `inst_data=0`, `inst_pc=0`.
  - State FETCH, pc=`RESET_PC`, queue empty, squash flag 0.
- `ic_valid`/`ic_addr`/`mem_req`/`mem_addr` are combinational from state and pc; `ic_valid` is forced 0 while `reset` is high.
- First lookup occurs in the first cycle after reset deasserts.
- Hit latency: `ic_valid` in cycle N, `ic_hit` sampled in N+1, `inst_valid` in N+2.
- Peak rate is one instruction per 2 cycles.
- Miss: `mem_req` rises in N+2. With `mem_ack` in cycle M, `inst_valid` rises in M+1 and the next `ic_valid` is in M+1.
- Redirect in cycle R: `inst_valid=0` in R+1. `ic_valid` with the new PC in R+1, unless in MISS awaiting `mem_ack`.
- Reset mid-operation: all state returns to reset values immediately; a pending memory request is abandoned.

## Configuration
- `IFETCH_PERF_EN` defined:
  - Adds outputs `perf_hits` (out, 32) and `perf_misses` (out, 32), both reset to 0.
  - `perf_hits` increments on each CHECK with `ic_hit=1`; `perf_misses` increments on each CHECK with `ic_hit=0`.
  - Squashed lookups still count. Both counters saturate at 32'hFFFF_FFFF.
- `IFETCH_PERF_EN` undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, cache always hits with data=PC^32'hA5A5_A5A5, `inst_ready=1`: `inst_pc` sequence 0,4,8,… each valid every other cycle, first `inst_valid` 2 cycles after first `ic_valid`.
- Miss at PC 0x10, `mem_ack` 3 cycles after `mem_req` with `mem_rdata`=32'hDEAD_BEEF: `mem_addr`=0x10, `inst_pc`=0x10/`inst_data`=DEAD_BEEF one cycle after ack, then lookup at 0x14.
- `inst_ready=0` with all hits: exactly `IQ_DEPTH` (4) entries, `ic_valid` then stays 0. Raising `inst_ready` drains PCs 0,4,8,C in order and fetch resumes at 0x10.
- Redirect to 0x1002 during MISS at 0x20, ack arrives 2 cycles later: queue empty, ack data not delivered, next `ic_addr`=0x1000.
- `redirect_pc`=0xFFFF_FFFC, hits: `inst_pc` 0xFFFF_FFFC then 0x0000_0000.
- With `IFETCH_PERF_EN`: 3 hits, 1 miss → `perf_hits`=3, `perf_misses`=1; async reset mid-MISS → both 0, `mem_req`=0.
